// File: rtl/mem_bus_arbiter.sv
// N-channel memory bus arbiter: round-robin or fixed-priority grant into a registered
// downstream request stage, with an in-order read-ID FIFO that routes read data back.
module mem_bus_arbiter #(
    parameter int NUM_CH          = 3,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = 0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_CH-1:0]        req_valid_in,
    output logic [NUM_CH-1:0]        req_ready_out,
    input  logic [NUM_CH-1:0]        req_we_in,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr_in,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata_in,
    output logic [NUM_CH-1:0]        rsp_valid_out,
    output logic [DATA_W-1:0]        rsp_data_out,
    output logic                     mem_valid_out,
    input  logic                     mem_ready_in,
    output logic                     mem_we_out,
    output logic [ADDR_W-1:0]        mem_addr_out,
    output logic [DATA_W-1:0]        mem_wdata_out,
    input  logic                     mem_rvalid_in,
    input  logic [DATA_W-1:0]        mem_rdata_in
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CH_W-1:0]     mem_ch_q, mem_ch_d;

    logic [CH_W-1:0]     fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_CH-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;

    logic                held_rd, rd_ok, found, grant, push, pop;
    logic [NUM_CH-1:0]   elig, win_oh, one_ch;
    logic [CH_W-1:0]     start, win;
    logic [CH_W:0]       idx;

    // A read parked in the output regs already owns a FIFO slot it will claim on acceptance.
    assign held_rd = mem_valid_q & ~mem_we_q;
    assign rd_ok   = (cnt_q + CNT_W'(held_rd)) < CNT_W'(MAX_OUTSTANDING);
    assign elig    = req_valid_in & (req_we_in | {NUM_CH{rd_ok}});
    assign start   = (ARB_MODE != 0) ? '0 : ptr_q;
    assign one_ch  = NUM_CH'(1);

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = {1'b0, start} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
            if (!found && elig[idx[CH_W-1:0]]) begin
                found = 1'b1;
                win   = idx[CH_W-1:0];
            end
        end
    end

    assign win_oh = one_ch << win;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                grant = found;
                if (found) state_d = HOLD;
            end
            HOLD: begin
                if (mem_ready_in) begin
                    grant = found;
                    if (!found) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_ch_d    = mem_ch_q;
        if (grant) begin
            mem_valid_d = 1'b1;
            mem_we_d    = req_we_in[win];
            mem_addr_d  = req_addr_in[int'(win)*ADDR_W +: ADDR_W];
            mem_wdata_d = req_wdata_in[int'(win)*DATA_W +: DATA_W];
            mem_ch_d    = win;
            if (ARB_MODE == 0)
                ptr_d = (win == CH_W'(NUM_CH-1)) ? '0 : win + 1'b1;
        end else if (state_q == HOLD && mem_ready_in) begin
            mem_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ch_q    <= mem_ch_d;
        end
    end

    // Read data with no outstanding ID is dropped rather than popping an empty FIFO.
    assign push = mem_valid_q & mem_ready_in & ~mem_we_q;
    assign pop  = mem_rvalid_in & (cnt_q != '0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_ch_q;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                rsp_data_q <= mem_rdata_in;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            rsp_valid_q <= pop ? (one_ch << fifo_q[rd_ptr_q]) : '0;
        end
    end

    assign req_ready_out = grant ? win_oh : '0;
    assign mem_valid_out = mem_valid_q;
    assign mem_we_out    = mem_we_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rsp_data_out  = rsp_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one round-robin and one fixed-priority instance
// share stimulus; a cycle table covers arbitration/FIFO, hand sequences cover reset.
module tb_mem_bus_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [2:0]  req_valid_in = '0, req_we_in = '0;
    logic [47:0] req_addr_in;
    logic [23:0] req_wdata_in;
    logic        mem_ready_in = 1'b0, mem_rvalid_in = 1'b0;
    logic [7:0]  mem_rdata_in = '0;

    logic [2:0]  rr_gnt, fp_gnt, rr_rsp, fp_rsp;
    logic [7:0]  rr_rdat, fp_rdat, rr_wdat, fp_wdat;
    logic        rr_mv, fp_mv, rr_we, fp_we;
    logic [15:0] rr_addr, fp_addr;

    logic [15:0] A [3] = '{16'h0A00, 16'h1234, 16'h2C00};
    logic [7:0]  W [3] = '{8'h50, 8'h51, 8'h52};
    assign req_addr_in  = {A[2], A[1], A[0]};
    assign req_wdata_in = {W[2], W[1], W[0]};

    int n_cmp = 0, n_err = 0;

    always #5 clk_in = ~clk_in;

    mem_bus_arbiter #(.NUM_CH(3), .ADDR_W(16), .DATA_W(8), .MAX_OUTSTANDING(4), .ARB_MODE(0)) u_rr (
        .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_ready_out(rr_gnt),
        .req_we_in(req_we_in), .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
        .rsp_valid_out(rr_rsp), .rsp_data_out(rr_rdat), .mem_valid_out(rr_mv),
        .mem_ready_in(mem_ready_in), .mem_we_out(rr_we), .mem_addr_out(rr_addr),
        .mem_wdata_out(rr_wdat), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in));

    mem_bus_arbiter #(.NUM_CH(3), .ADDR_W(16), .DATA_W(8), .MAX_OUTSTANDING(4), .ARB_MODE(1)) u_fp (
        .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_ready_out(fp_gnt),
        .req_we_in(req_we_in), .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
        .rsp_valid_out(fp_rsp), .rsp_data_out(fp_rdat), .mem_valid_out(fp_mv),
        .mem_ready_in(mem_ready_in), .mem_we_out(fp_we), .mem_addr_out(fp_addr),
        .mem_wdata_out(fp_wdat), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in));

    typedef struct {
        bit         rst;
        bit         fp;
        logic [2:0] v, we;
        logic       rdy, rv;
        logic [7:0] rd;
        logic [2:0] gnt;
        logic       mv;
        int         ch;
        logic       mwe;
        logic [2:0] rsp;
        logic [7:0] rdat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit fp, logic [2:0] v, logic [2:0] we, logic rdy,
                                logic rv, logic [7:0] rd, logic [2:0] gnt, logic mv, int ch,
                                logic mwe, logic [2:0] rsp, logic [7:0] rdat);
        vec_t t;
        t.rst = rst; t.fp = fp; t.v = v; t.we = we; t.rdy = rdy; t.rv = rv; t.rd = rd;
        t.gnt = gnt; t.mv = mv; t.ch = ch; t.mwe = mwe; t.rsp = rsp; t.rdat = rdat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] we, input logic rdy,
                         input logic rv, input logic [7:0] rd);
        req_valid_in = v; req_we_in = we; mem_ready_in = rdy; mem_rvalid_in = rv; mem_rdata_in = rd;
    endtask

    task automatic step();
        @(posedge clk_in); #1;
    endtask

    task automatic reset_dut();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 8'h00);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        step();
    endtask

    initial begin
        // single read ch1 @0x1234, data 0xA5 two cycles after acceptance
        tbl.push_back(mk(1,0,3'b010,3'b000,1,0,8'h00, 3'b010,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,1,1,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,1,8'hA5, 3'b000,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,0,0,0,3'b010,8'hA5));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,0,0,0,3'b000,8'h00));
        // round-robin fairness, all channels writing continuously
        tbl.push_back(mk(1,0,3'b111,3'b111,1,0,8'h00, 3'b001,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b111,3'b111,1,0,8'h00, 3'b010,1,0,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b111,3'b111,1,0,8'h00, 3'b100,1,1,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b111,3'b111,1,0,8'h00, 3'b001,1,2,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b111,3'b111,1,0,8'h00, 3'b010,1,0,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b111,3'b111,1,0,8'h00, 3'b100,1,1,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,1,2,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,0,0,0,3'b000,8'h00));
        // downstream backpressure holds the ch2 write stable
        tbl.push_back(mk(1,0,3'b100,3'b100,0,0,8'h00, 3'b100,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,0,0,8'h00, 3'b000,1,2,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,0,0,8'h00, 3'b000,1,2,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,1,0,8'h00, 3'b001,1,2,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,1,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,0,0,0,3'b000,8'h00));
        // FIFO full: 5th read stalls, a ch2 write still passes, one rvalid frees a slot
        tbl.push_back(mk(1,0,3'b001,3'b000,1,0,8'h00, 3'b001,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,1,0,8'h00, 3'b001,1,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,1,0,8'h00, 3'b001,1,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,1,0,8'h00, 3'b001,1,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,1,0,8'h00, 3'b000,1,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b101,3'b100,1,0,8'h00, 3'b100,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,1,0,8'h00, 3'b000,1,2,1,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,1,1,8'h77, 3'b000,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,1,0,8'h00, 3'b001,0,0,0,3'b001,8'h77));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,1,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,0,0,0,3'b000,8'h00));
        // read IDs ch2, ch0, ch1 routed back in issue order; stray rvalid when empty
        tbl.push_back(mk(1,0,3'b100,3'b000,1,0,8'h00, 3'b100,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b001,3'b000,1,0,8'h00, 3'b001,1,2,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b010,3'b000,1,0,8'h00, 3'b010,1,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,1,1,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,1,8'h11, 3'b000,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,1,8'h22, 3'b000,0,0,0,3'b100,8'h11));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,1,8'h33, 3'b000,0,0,0,3'b001,8'h22));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,0,0,0,3'b010,8'h33));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,1,8'hEE, 3'b000,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,0,3'b000,3'b000,1,0,8'h00, 3'b000,0,0,0,3'b000,8'h00));
        // fixed priority: ch0 wins while valid, ch2 follows
        tbl.push_back(mk(1,1,3'b101,3'b101,1,0,8'h00, 3'b001,0,0,0,3'b000,8'h00));
        tbl.push_back(mk(0,1,3'b101,3'b101,1,0,8'h00, 3'b001,1,0,1,3'b000,8'h00));
        tbl.push_back(mk(0,1,3'b101,3'b101,1,0,8'h00, 3'b001,1,0,1,3'b000,8'h00));
        tbl.push_back(mk(0,1,3'b101,3'b101,1,0,8'h00, 3'b001,1,0,1,3'b000,8'h00));
        tbl.push_back(mk(0,1,3'b100,3'b100,1,0,8'h00, 3'b100,1,0,1,3'b000,8'h00));
        tbl.push_back(mk(0,1,3'b000,3'b000,1,0,8'h00, 3'b000,1,2,1,3'b000,8'h00));
        tbl.push_back(mk(0,1,3'b000,3'b000,1,0,8'h00, 3'b000,0,0,0,3'b000,8'h00));

        // power-on reset state
        drive(3'b000, 3'b000, 1'b0, 1'b0, 8'h00);
        #1;
        chk("rst rr mv", rr_mv, 0);
        chk("rst rr addr", rr_addr, 0);
        chk("rst rr rsp", rr_rsp, 0);
        chk("rst fp mv", fp_mv, 0);
        chk("rst rr gnt", rr_gnt, 0);
        step();
        reset_dut();

        for (int i = 0; i < tbl.size(); i++) begin
            logic [2:0]  g, r;
            logic        m, w;
            logic [15:0] a;
            logic [7:0]  wd, rdv;
            if (tbl[i].rst) reset_dut();
            drive(tbl[i].v, tbl[i].we, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
            @(negedge clk_in);
            g  = tbl[i].fp ? fp_gnt  : rr_gnt;
            m  = tbl[i].fp ? fp_mv   : rr_mv;
            w  = tbl[i].fp ? fp_we   : rr_we;
            a  = tbl[i].fp ? fp_addr : rr_addr;
            wd = tbl[i].fp ? fp_wdat : rr_wdat;
            r  = tbl[i].fp ? fp_rsp  : rr_rsp;
            rdv = tbl[i].fp ? fp_rdat : rr_rdat;
            chk($sformatf("v%0d req_ready", i), g, tbl[i].gnt);
            chk($sformatf("v%0d mem_valid", i), m, tbl[i].mv);
            if (tbl[i].mv) begin
                chk($sformatf("v%0d mem_addr", i), a, A[tbl[i].ch]);
                chk($sformatf("v%0d mem_we", i), w, tbl[i].mwe);
                if (tbl[i].mwe) chk($sformatf("v%0d mem_wdata", i), wd, W[tbl[i].ch]);
            end
            chk($sformatf("v%0d rsp_valid", i), r, tbl[i].rsp);
            if (tbl[i].rsp != 3'b000) chk($sformatf("v%0d rsp_data", i), rdv, tbl[i].rdat);
            step();
        end

        // asynchronous reset while holding a read with two outstanding
        reset_dut();
        drive(3'b001, 3'b000, 1'b1, 1'b0, 8'h00); step();
        drive(3'b010, 3'b000, 1'b1, 1'b0, 8'h00); step();
        drive(3'b100, 3'b000, 1'b1, 1'b0, 8'h00); step();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 8'h00);
        @(negedge clk_in);
        chk("hold mv", rr_mv, 1);
        chk("hold addr", rr_addr, A[2]);
        rst_in = 1'b0;
        #1;
        chk("async mv", rr_mv, 0);
        chk("async addr", rr_addr, 0);
        chk("async we", rr_we, 0);
        chk("async rsp", rr_rsp, 0);
        chk("async fp mv", fp_mv, 0);
        #2;
        rst_in = 1'b1;
        drive(3'b000, 3'b000, 1'b1, 1'b1, 8'h5A); step();
        drive(3'b000, 3'b000, 1'b1, 1'b0, 8'h00);
        @(negedge clk_in);
        chk("stray rsp", rr_rsp, 0);
        step();
        drive(3'b001, 3'b000, 1'b1, 1'b0, 8'h00); step();
        drive(3'b000, 3'b000, 1'b1, 1'b0, 8'h00);
        @(negedge clk_in);
        chk("post mv", rr_mv, 1);
        chk("post addr", rr_addr, A[0]);
        step();
        step();
        drive(3'b000, 3'b000, 1'b1, 1'b1, 8'hC3); step();
        drive(3'b000, 3'b000, 1'b1, 1'b0, 8'h00);
        @(negedge clk_in);
        chk("post rsp", rr_rsp, 3'b001);
        chk("post rdata", rr_rdat, 8'hC3);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
